// File: rtl/aec_pkg.sv
// aec_pkg: shared ASCII constants, legal-character test and feeder state type for the expression calculator front end.
package aec_pkg;
  localparam logic [7:0] ASC_EQ  = 8'h3D;
  localparam logic [7:0] ASC_SP  = 8'h20;
  localparam logic [7:0] ASC_LP  = 8'h28;
  localparam logic [7:0] ASC_RP  = 8'h29;
  localparam logic [7:0] ASC_MUL = 8'h2A;
  localparam logic [7:0] ASC_ADD = 8'h2B;
  localparam logic [7:0] ASC_SUB = 8'h2D;
  typedef enum logic [1:0] {COLLECT, DISCARD, SEND, WAIT_RES} feeder_state_t;
  function automatic logic is_legal_char(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46) ||
           c == ASC_LP || c == ASC_RP || c == ASC_MUL || c == ASC_ADD || c == ASC_SUB || c == ASC_EQ;
  endfunction
endpackage

// File: rtl/aec_char_buf.sv
// aec_char_buf: DEPTH x 8 register file with one write port and a registered read port.
module aec_char_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] r_mem [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_mem <= '{default: '0};
      rdata <= '0;
    end else begin
      if (we) r_mem[waddr] <= wdata;
      rdata <= r_mem[raddr];
    end
endmodule

// File: rtl/aec_expr_feeder.sv
// aec_expr_feeder: buffers one validated expression up to '=' and replays it to the calculator.
// Optional parenthesis balance checking is enabled by defining AEC_PAREN_CHECK_EN.
module aec_expr_feeder import aec_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_ready,
  output logic [7:0] out_ascii,
  input  logic       calc_valid,
  output logic       busy,
  output logic       err
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);
  feeder_state_t r_state, w_state_n;
  logic [CNT_W-1:0] r_fill, w_fill_n, r_rd, w_rd_n;
  logic r_err, w_err_n, r_live, w_we, w_xfer, w_eq;
  logic [AW-1:0] w_raddr;
  logic [7:0] w_rdata;
`ifdef AEC_PAREN_CHECK_EN
  localparam logic signed [CNT_W:0] ONE = 1;
  logic signed [CNT_W:0] r_depth, w_depth_n;
`endif
  assign w_xfer    = in_valid & in_ready;
  assign w_eq      = in_data == ASC_EQ;
  assign in_ready  = r_live & (r_state == COLLECT || r_state == DISCARD);
  assign out_ready = r_state == SEND;
  assign out_ascii = out_ready ? w_rdata : 8'h00;
  assign busy      = r_state == SEND || r_state == WAIT_RES;
  assign err       = r_err;
  // Read one ahead so buf[0] is already on rdata the cycle SEND starts.
  assign w_raddr   = r_state == SEND ? AW'(r_rd + 1'b1) : '0;
  aec_char_buf #(.DEPTH(DEPTH)) u_buf (
    .clk(clk), .rst(rst), .we(w_we), .waddr(r_fill[AW-1:0]), .wdata(in_data),
    .raddr(w_raddr), .rdata(w_rdata)
  );
  always_comb begin
    w_state_n = r_state;
    w_fill_n  = r_fill;
    w_rd_n    = r_rd;
    w_err_n   = 1'b0;
    w_we      = 1'b0;
`ifdef AEC_PAREN_CHECK_EN
    w_depth_n = r_depth;
`endif
    case (r_state)
      COLLECT: if (w_xfer && in_data != ASC_SP) begin
        if (!is_legal_char(in_data) || (!w_eq && r_fill == CNT_W'(DEPTH - 1))) begin
          w_err_n   = 1'b1;
          w_state_n = DISCARD;
`ifdef AEC_PAREN_CHECK_EN
          w_depth_n = '0;
        end else if (in_data == ASC_RP && r_depth == 0) begin
          w_err_n   = 1'b1;
          w_state_n = DISCARD;
          w_depth_n = '0;
        end else if (w_eq && r_depth != 0) begin
          w_err_n   = 1'b1;
          w_fill_n  = '0;
          w_depth_n = '0;
`endif
        end else if (w_eq && r_fill == '0) begin
          w_err_n = 1'b1;
        end else begin
          w_we     = 1'b1;
          w_fill_n = r_fill + 1'b1;
`ifdef AEC_PAREN_CHECK_EN
          w_depth_n = w_eq ? '0 : in_data == ASC_LP ? r_depth + ONE : in_data == ASC_RP ? r_depth - ONE : r_depth;
`endif
          if (w_eq) begin
            w_state_n = SEND;
            w_rd_n    = '0;
          end
        end
      end
      DISCARD: if (w_xfer && w_eq) begin
        w_state_n = COLLECT;
        w_fill_n  = '0;
      end
      SEND: begin
        w_rd_n = r_rd + 1'b1;
        if (r_rd == r_fill - 1'b1) w_state_n = WAIT_RES;
      end
      default: if (calc_valid) begin
        w_state_n = COLLECT;
        w_fill_n  = '0;
        w_rd_n    = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= COLLECT;
      r_fill  <= '0;
      r_rd    <= '0;
      r_err   <= 1'b0;
      r_live  <= 1'b0;
`ifdef AEC_PAREN_CHECK_EN
      r_depth <= '0;
`endif
    end else begin
      r_state <= w_state_n;
      r_fill  <= w_fill_n;
      r_rd    <= w_rd_n;
      r_err   <= w_err_n;
      r_live  <= 1'b1;
`ifdef AEC_PAREN_CHECK_EN
      r_depth <= w_depth_n;
`endif
    end
endmodule

// File: tb/tb_aec_expr_feeder.sv
// tb_aec_expr_feeder: scoreboard bench; expected replay chars are queued as stimulus is driven.
module tb_aec_expr_feeder;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, calc_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, out_ready, busy, err;
  logic [7:0] out_ascii;
  int checks = 0, errors = 0, n_out = 0, n_err = 0;
  logic [7:0] q[$];

  aec_expr_feeder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_ready(out_ready), .out_ascii(out_ascii), .calc_valid(calc_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) if (!rst) begin
    if (err) n_err++;
    if (out_ready) begin
      logic [7:0] e;
      n_out++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL replay_extra got %h expected nothing", out_ascii);
      end else begin
        e = q.pop_front();
        if (out_ascii !== e) begin
          errors++;
          $display("FAIL replay_char got %h expected %h", out_ascii, e);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] c);
    int t = 0;
    in_valid = 1'b1;
    in_data  = c;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      errors++;
      $display("FAIL send_timeout got in_ready=%b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_expr(input string s, input bit ok, input int hold);
    int n0 = n_out, e0 = n_err, len = 0, t = 0;
    if (ok) for (int i = 0; i < s.len(); i++) if (s[i] != " ") begin
      q.push_back(s[i]);
      len++;
    end
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    if (ok) begin
      while (!(busy && !out_ready) && t < 40) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (t >= 40) begin errors++; $display("FAIL wait_res_timeout %s got busy=%b expected WAIT_RES", s, busy); end
      checks++;
      if (n_out - n0 != len) begin errors++; $display("FAIL replay_len %s got %0d expected %0d", s, n_out - n0, len); end
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL replay_left %s got %0d expected 0", s, q.size()); end
      checks++;
      if (n_err != e0) begin errors++; $display("FAIL spurious_err %s got %0d expected 0", s, n_err - e0); end
      repeat (hold) begin
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL backpressure got %b expected 0", in_ready); end
      end
      calc_valid = 1'b1;
      @(negedge clk);
      calc_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL release got in_ready=%b busy=%b expected 1 0", in_ready, busy);
      end
    end else begin
      repeat (2) @(negedge clk);
      checks++;
      if (n_err - e0 != 1) begin errors++; $display("FAIL err_count %s got %0d expected 1", s, n_err - e0); end
      checks++;
      if (n_out != n0) begin errors++; $display("FAIL dropped_replay %s got %0d expected 0", s, n_out - n0); end
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL after_drop got busy=%b in_ready=%b expected 0 1", busy, in_ready);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_ready !== 1'b0 || out_ascii !== 8'h00 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b %b %h %b %b expected 0 0 00 0 0", in_ready, out_ready, out_ascii, busy, err);
    end
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_cycle_ready got %b expected 0", in_ready); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    run_expr("3+4*2=", 1'b1, 5);
  endtask

  task automatic test_spaces();
    run_expr("( 1 + a ) =", 1'b1, 0);
  endtask

  task automatic test_illegal();
    run_expr("2#3=", 1'b0, 0);
    run_expr("5=", 1'b1, 0);
    run_expr("=", 1'b0, 0);
  endtask

  task automatic test_overflow();
    string d = "1234567890123456";
    int n0 = n_out, e0 = n_err;
    for (int i = 0; i < 15; i++) send_byte(d[i]);
    checks++;
    if (n_err != e0 || err !== 1'b0) begin errors++; $display("FAIL overflow_early got %0d expected 0", n_err - e0); end
    send_byte(d[15]);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL overflow_err got %b expected 1", err); end
    send_byte("=");
    repeat (3) @(negedge clk);
    checks++;
    if (n_err - e0 != 1 || n_out != n0) begin
      errors++;
      $display("FAIL overflow_drop got err=%0d out=%0d expected 1 0", n_err - e0, n_out - n0);
    end
    run_expr("12345678901234a=", 1'b1, 0);
  endtask

  task automatic test_paren();
`ifdef AEC_PAREN_CHECK_EN
    run_expr("(1+2=", 1'b0, 0);
    run_expr(")1=", 1'b0, 0);
`else
    run_expr("(1+2=", 1'b1, 0);
    run_expr(")1=", 1'b1, 0);
`endif
  endtask

  task automatic test_reset_mid();
    string s = "9-1=";
    int t = 0, e0;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    while (!out_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    e0 = n_err;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_ready !== 1'b0 || out_ascii !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got out_ready=%b out_ascii=%h busy=%b expected 0 00 0", out_ready, out_ascii, busy);
    end
    q.delete();
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got %b expected 0", in_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || n_err != e0) begin
      errors++;
      $display("FAIL mid_reset_release got in_ready=%b err=%0d expected 1 0", in_ready, n_err - e0);
    end
    run_expr("7=", 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_spaces();
    test_illegal();
    test_overflow();
    test_paren();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
